// File: rtl/ring_counter_onehot.sv
// One-hot ring counter with direction select, preload and self-correction.
// A single '1' rotates one position per enabled clock.
module ring_counter_onehot #(
  parameter int WIDTH    = 4,
  parameter int INIT_POS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             wrap,
  output logic             err
);

  localparam logic [WIDTH-1:0] SEED =
    WIDTH'(1) << INIT_POS;

  logic [WIDTH-1:0] out_d, out_q;
  logic             err_d, err_q;

  logic             cur_ok;
  logic             ld_ok;
  logic [WIDTH-1:0] rot_v;

  logic sel_ld_ok;
  logic sel_ld_bad;
  logic sel_fix;
  logic sel_rot;

  function automatic logic onehot(
    input logic [WIDTH-1:0] v
  );
    int cnt;
    cnt = 0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt += int'(v[i]);
    end
    return cnt == 1;
  endfunction

  function automatic logic [WIDTH-1:0] rotate(
    input logic [WIDTH-1:0] v,
    input logic             d
  );
    if (d) begin
      return {v[0], v[WIDTH-1:1]};
    end
    return {v[WIDTH-2:0], v[WIDTH-1]};
  endfunction

  // Legality checks and the rotated candidate.
  always_comb begin
    cur_ok = onehot(out_q);
    ld_ok  = onehot(load_val);
    rot_v  = rotate(out_q, dir);
  end

  // Mutually exclusive rule selects, load first, then repair, then rotate.
  always_comb begin
    sel_ld_ok  = load & ld_ok;
    sel_ld_bad = load & ~ld_ok;
    sel_fix    = ~load & ~cur_ok;
    sel_rot    = ~load & cur_ok & en;
  end

  // Next-state selection for ring and error flag.
  always_comb begin
    out_d = out_q;
    err_d = 1'b0;
    unique case (1'b1)
      sel_ld_ok: begin
        out_d = load_val;
      end
      sel_ld_bad: begin
        out_d = SEED;
        err_d = 1'b1;
      end
      sel_fix: begin
        out_d = SEED;
        err_d = 1'b1;
      end
      sel_rot: begin
        out_d = rot_v;
      end
      default: begin
        out_d = out_q;
      end
    endcase
  end

  // State registers, asynchronously returned to the seed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= SEED;
      err_q <= 1'b0;
    end else begin
      out_q <= out_d;
      err_q <= err_d;
    end
  end

  // Wrap looks one edge ahead; never asserted from an illegal state.
  always_comb begin
    wrap = en & ~load & cur_ok &
           (rot_v == SEED);
  end

  assign out = out_q;
  assign err = err_q;

endmodule

// File: tb/tb_ring_counter_onehot.sv
// Directed bench for ring_counter_onehot (WIDTH=4, INIT_POS=0).
// Inputs change and outputs are sampled on the falling edge.
module tb_ring_counter_onehot;

  logic       clk;
  logic       rst;
  logic       en;
  logic       dir;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] out;
  logic       wrap;
  logic       err;

  int checks;
  int errors;

  ring_counter_onehot #(
    .WIDTH   (4),
    .INIT_POS(0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .dir     (dir),
    .load    (load),
    .load_val(load_val),
    .out     (out),
    .wrap    (wrap),
    .err     (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk4(
    input string      tag,
    input logic [3:0] obs,
    input logic [3:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b",
             tag, obs, exp);
    end
  endtask

  task automatic chk1(
    input string tag,
    input logic  obs,
    input logic  exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [3:0] seq_l [8];
  logic [3:0] seq_r [5];

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    en       = 1'b0;
    dir      = 1'b0;
    load     = 1'b0;
    load_val = 4'b0000;
    seq_l = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
              4'b0001, 4'b0010, 4'b0100, 4'b1000};
    seq_r = '{4'b0001, 4'b1000, 4'b0100, 4'b0010,
              4'b0001};

    // reset hold: clocks run, state stays at seed
    @(negedge clk);
    @(negedge clk);
    chk4("rst_out", out, 4'b0001);
    chk1("rst_err", err, 1'b0);

    // 1: left rotation, wrap while out=1000
    rst = 1'b1;
    en  = 1'b1;
    dir = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk4($sformatf("left_out%0d", i), out, seq_l[i]);
      chk1($sformatf("left_wrap%0d", i), wrap,
           seq_l[i] == 4'b1000);
      chk1($sformatf("left_err%0d", i), err, 1'b0);
      step();
    end
    chk4("left_final", out, 4'b0001);

    // 2: right rotation from reset, wrap while out=0010
    rst = 1'b0;
    #1;
    chk4("rst2_out", out, 4'b0001);
    @(negedge clk);
    rst = 1'b1;
    dir = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk4($sformatf("right_out%0d", i), out, seq_r[i]);
      chk1($sformatf("right_wrap%0d", i), wrap,
           seq_r[i] == 4'b0010);
      if (i < 4) step();
    end

    // 3: hold with en=0 at 0100
    step();
    step();
    chk4("pre_hold", out, 4'b0100);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk4($sformatf("hold_out%0d", i), out, 4'b0100);
      chk1($sformatf("hold_wrap%0d", i), wrap, 1'b0);
      chk1($sformatf("hold_err%0d", i), err, 1'b0);
    end

    // 4: preload legal then illegal
    en  = 1'b1;
    dir = 1'b0;
    step();
    chk4("pre_load", out, 4'b1000);
    chk1("pre_load_wrap", wrap, 1'b1);
    load     = 1'b1;
    load_val = 4'b0100;
    #1;
    chk1("load_wrap_sup", wrap, 1'b0);
    step();
    chk4("load_ok_out", out, 4'b0100);
    chk1("load_ok_err", err, 1'b0);
    load_val = 4'b0110;
    step();
    chk4("load_bad_out", out, 4'b0001);
    chk1("load_bad_err", err, 1'b1);
    load = 1'b0;
    en   = 1'b0;
    step();
    chk4("load_bad_after", out, 4'b0001);
    chk1("load_bad_err_clr", err, 1'b0);

    // 5: corrupted state repairs to seed
    en = 1'b1;
    force dut.out_q = 4'b0000;
    #1;
    release dut.out_q;
    #1;
    chk4("zero_out", out, 4'b0000);
    chk1("zero_wrap", wrap, 1'b0);
    step();
    chk4("zero_fix_out", out, 4'b0001);
    chk1("zero_fix_err", err, 1'b1);
    step();
    chk4("zero_resume_out", out, 4'b0010);
    chk1("zero_resume_err", err, 1'b0);
    force dut.out_q = 4'b1010;
    #1;
    release dut.out_q;
    #1;
    chk1("multi_wrap", wrap, 1'b0);
    en = 1'b0;
    step();
    chk4("multi_fix_out", out, 4'b0001);
    chk1("multi_fix_err", err, 1'b1);

    // 6: async reset mid-rotation
    en = 1'b1;
    step();
    step();
    step();
    chk4("pre_arst", out, 4'b1000);
    #2;
    rst = 1'b0;
    #1;
    chk4("arst_out", out, 4'b0001);
    chk1("arst_err", err, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk4("arst_resume", out, 4'b0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
